// File: rtl/dclk_pkg.sv
// Shared types, segment patterns and BCD time helpers for the digital clock core.
package dclk_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t h_t;
        bcd_digit_t h_u;
        bcd_digit_t m_t;
        bcd_digit_t m_u;
        bcd_digit_t s_t;
        bcd_digit_t s_u;
    } time_bcd_t;

    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] DP_MASK   = 8'b0111_1111;

    function automatic logic time_valid(input time_bcd_t t, input logic mode24);
        logic ok;
        ok = (t.s_u <= 4'd9) && (t.s_t <= 4'd5) &&
             (t.m_u <= 4'd9) && (t.m_t <= 4'd5) &&
             (t.h_u <= 4'd9);
        if (mode24)
            ok = ok && ((t.h_t < 4'd2) || (t.h_t == 4'd2 && t.h_u <= 4'd3));
        else
            ok = ok && ((t.h_t == 4'd0 && t.h_u != 4'd0) ||
                        (t.h_t == 4'd1 && t.h_u <= 4'd2));
        return ok;
    endfunction

    // One-second advance with the full carry chain resolved in a single step.
    function automatic time_bcd_t time_inc(input time_bcd_t t, input logic mode24);
        time_bcd_t n;
        n = t;
        if (t.s_u != 4'd9) begin
            n.s_u = t.s_u + 4'd1;
        end else begin
            n.s_u = 4'd0;
            if (t.s_t != 4'd5) begin
                n.s_t = t.s_t + 4'd1;
            end else begin
                n.s_t = 4'd0;
                if (t.m_u != 4'd9) begin
                    n.m_u = t.m_u + 4'd1;
                end else begin
                    n.m_u = 4'd0;
                    if (t.m_t != 4'd5) begin
                        n.m_t = t.m_t + 4'd1;
                    end else begin
                        n.m_t = 4'd0;
                        if (mode24 && t.h_t == 4'd2 && t.h_u == 4'd3) begin
                            n.h_t = 4'd0;
                            n.h_u = 4'd0;
                        end else if (!mode24 && t.h_t == 4'd1 && t.h_u == 4'd2) begin
                            n.h_t = 4'd0;
                            n.h_u = 4'd1;
                        end else if (t.h_u == 4'd9) begin
                            n.h_t = t.h_t + 4'd1;
                            n.h_u = 4'd0;
                        end else begin
                            n.h_u = t.h_u + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module bcd_to_seg
    import dclk_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_time_core.sv
// hh:mm:ss BCD clock with validated time-set handshake and 6-digit multiplexed display.
// Optional alarm pulse output enabled by defining DCLK_ALARM_EN.
module clock_time_core
    import dclk_pkg::*;
#(
    parameter int          MODE_24H   = 1,
    parameter int          NUM_DIGITS = 6,
    parameter logic [23:0] RESET_TIME = 24'h000000
) (
    input  logic        high,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic        scan_tick,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic [23:0] time_bcd,
    output logic [5:0]  an_n,
    output logic [7:0]  seg_n
`ifdef DCLK_ALARM_EN
    ,
    input  logic [23:0] alarm_time,
    output logic        alarm_hit
`endif
);

    if (NUM_DIGITS != 6) begin : g_bad_digits
        $error("clock_time_core supports exactly 6 display digits");
    end

    localparam logic MODE24 = (MODE_24H != 0);

    state_t     r_state;
    time_bcd_t  r_time;
    logic [2:0] r_idx;
    logic       r_set_ready;
    logic       r_set_err;
    logic [5:0] r_an_n;
    logic [7:0] r_seg_n;

    logic       w_accept;
    logic       w_set_ok;
    logic       w_tick_apply;
    time_bcd_t  w_inc;
    time_bcd_t  w_time_nxt;
    logic [23:0] w_time_flat;
    logic [2:0] w_idx_nxt;
    logic [3:0] w_nib;
    logic [6:0] w_seg7;
    logic       w_dp;

    always_comb begin
        w_accept     = (r_state == RUN) && set_valid;
        w_set_ok     = time_valid(time_bcd_t'(set_time), MODE24);
        w_inc        = time_inc(r_time, MODE24);
        // A rejected set leaves the tick alive; an accepted one swallows it.
        w_tick_apply = sec_tick && (r_state == RUN) && !(w_accept && w_set_ok);

        if (rst)
            w_time_nxt = time_bcd_t'(RESET_TIME);
        else if (w_accept && w_set_ok)
            w_time_nxt = time_bcd_t'(set_time);
        else if (w_tick_apply)
            w_time_nxt = w_inc;
        else
            w_time_nxt = r_time;

        if (rst)
            w_idx_nxt = 3'd0;
        else if (scan_tick)
            w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        else
            w_idx_nxt = r_idx;

        // Decode from next-state values so the display tracks time changes without a scan.
        w_time_flat = w_time_nxt;
        w_nib       = w_time_flat[{w_idx_nxt, 2'b00} +: 4];
        w_dp        = (w_idx_nxt == 3'd2) || (w_idx_nxt == 3'd4);
    end

    bcd_to_seg u_dec (
        .i_bcd   (w_nib),
        .o_seg_n (w_seg7)
    );

    always_ff @(posedge high) begin
        if (rst) begin
            r_state     <= RUN;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
        end else begin
            r_set_err <= 1'b0;
            case (r_state)
                RUN: begin
                    if (set_valid) begin
                        if (w_set_ok) begin
                            r_state     <= LOAD;
                            r_set_ready <= 1'b0;
                        end else begin
                            r_set_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_state     <= RUN;
                    r_set_ready <= 1'b1;
                end
                default: begin
                    r_state     <= RUN;
                    r_set_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge high) begin
        r_time  <= w_time_nxt;
        r_idx   <= w_idx_nxt;
        r_an_n  <= ~(6'b000001 << w_idx_nxt);
        r_seg_n <= {1'b1, w_seg7} & (w_dp ? DP_MASK : 8'hFF);
    end

`ifdef DCLK_ALARM_EN
    logic r_alarm_hit;

    always_ff @(posedge high) begin
        if (rst)
            r_alarm_hit <= 1'b0;
        else
            r_alarm_hit <= w_tick_apply && (w_inc == time_bcd_t'(alarm_time));
    end

    assign alarm_hit = r_alarm_hit;
`endif

    assign set_ready = r_set_ready;
    assign set_err   = r_set_err;
    assign time_bcd  = r_time;
    assign an_n      = r_an_n;
    assign seg_n     = r_seg_n;

endmodule
